// File: rtl/lotr_io_pkg.sv
// Shared definitions for the lotr board-input capture block:
// register map, input bit map and the queued event record.
package lotr_io_pkg;

  // Register addresses on the read/write port
  localparam logic [1:0] IO_LEVEL  = 2'd0;
  localparam logic [1:0] IO_EVENT  = 2'd1;
  localparam logic [1:0] IO_STATUS = 2'd2;
  localparam logic [1:0] IO_MASK   = 2'd3;

  // Position of each board input group inside the input vector
  localparam int unsigned SW_LSB  = 0;
  localparam int unsigned BTN_LSB = 10;
  localparam int unsigned ARD_LSB = 12;

  // One queued edge event
  typedef struct packed {
    logic [15:0] ts;
    logic        valid;
    logic        edge_rise;
    logic [4:0]  idx;
  } io_event_t;

  localparam int unsigned EVENT_W = $bits(io_event_t);

  // Place an event record into its 32-bit read-port layout
  function automatic logic [31:0] event_word(input io_event_t ev);
    return {ev.ts, ev.valid, 6'b0, ev.edge_rise, 3'b0, ev.idx};
  endfunction

endpackage

// File: rtl/lotr_io_fifo.sv
// Small synchronous FIFO for edge events. Pop on empty is ignored;
// push while full is accepted only when a pop happens in the same cycle.
module lotr_io_fifo #(
  parameter int unsigned W     = 23,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [W-1:0]                   i_wdata,
  output logic [W-1:0]                   o_rdata_c,
  output logic                           o_full_c,
  output logic                           o_empty_c,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata_c = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty_c;
  assign w_do_push = i_push & (~o_full_c | w_do_pop);

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/lotr_io_in_capture.sv
// Board input capture for lotr: synchronizes and debounces raw board
// inputs, queues debounced edges as events and exposes levels, events,
// status and the edge mask on a 1-cycle-latency register port.
// Optional build macro LOTR_IO_TIMESTAMP_EN adds a 16-bit tick counter
// whose value is stamped into each event at push time.
module lotr_io_in_capture
  import lotr_io_pkg::*;
#(
  parameter int unsigned     IN_W       = 28,
  parameter int unsigned     TICK_DIV   = 5000,
  parameter int unsigned     DEB_TICKS  = 3,
  parameter int unsigned     FIFO_DEPTH = 8,
  parameter logic [IN_W-1:0] RST_VAL    = IN_W'(28'h0000C00)
) (
  input  logic            QClk,
  input  logic            RstQnnnH,
  input  logic [IN_W-1:0] AsyncIn,
  input  logic            RdEn,
  input  logic [1:0]      RdAddr,
  output logic [31:0]     RdData,
  output logic            RdValid,
  input  logic            WrEn,
  input  logic [1:0]      WrAddr,
  input  logic [31:0]     WrData,
  output logic            IrqPending
);

  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);

  logic [IN_W-1:0]  r_sync1;
  logic [IN_W-1:0]  r_sync2;
  logic [IN_W-1:0]  r_stable;
  logic [CNT_W-1:0] r_cnt [IN_W];
  logic [PW-1:0]    r_presc;
  logic [IN_W-1:0]  r_pend;
  logic [IN_W-1:0]  r_pend_type;
  logic             r_ovf;
  logic [IN_W-1:0]  r_mask;
  logic [31:0]      r_rd_data;
  logic             r_rd_valid;
  logic             r_irq;

  logic             w_tick;
  logic [IN_W-1:0]  w_stable_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [IN_W];
  logic [IN_W-1:0]  w_edge;
  logic [IN_W-1:0]  w_set;
  logic [IN_W-1:0]  w_sel_oh;
  logic [IN_W-1:0]  w_clr;
  logic [4:0]       w_sel_idx;
  logic             w_sel_vld;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [FCW-1:0]   w_count;
  logic [15:0]      w_ts;
  io_event_t        w_push_ev;
  io_event_t        w_head;
  logic [31:0]      w_rd_c;
  logic             w_unused_wrdata;

  assign w_unused_wrdata = &{1'b0, WrData[31:IN_W]};

`ifdef LOTR_IO_TIMESTAMP_EN
  logic [15:0] r_ts;

  // Free-running timestamp advanced once per debounce tick
  always_ff @(posedge QClk) begin
    if (RstQnnnH) r_ts <= '0;
    else if (w_tick) r_ts <= r_ts + 16'd1;
  end

  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif

  // Two-flop synchronizer for every raw input bit
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
    end else begin
      r_sync1 <= AsyncIn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  // Debounce sample-tick prescaler
  always_ff @(posedge QClk) begin
    if (RstQnnnH)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // Per-bit debounce: accept a new level after DEB_TICKS disagreeing ticks
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt;
    w_edge       = '0;
    if (w_tick) begin
      for (int i = 0; i < int'(IN_W); i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == CNT_W'(DEB_TICKS - 1)) begin
            w_stable_nxt[i] = r_sync2[i];
            w_cnt_nxt[i]    = '0;
            w_edge[i]       = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt[i] = '0;
        end
      end
    end
  end

  // Lowest-index pending bit wins the single push slot
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_sel_oh  = '0;
    for (int i = int'(IN_W) - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = 5'(i);
        w_sel_oh  = '0;
        w_sel_oh[i] = 1'b1;
      end
    end
  end

  assign w_pop  = RdEn & (RdAddr == IO_EVENT) & ~w_empty;
  assign w_push = w_sel_vld & (~w_full | w_pop);
  assign w_clr  = w_push ? w_sel_oh : '0;
  assign w_set  = w_edge & r_mask;

  assign w_push_ev.ts        = w_ts;
  assign w_push_ev.valid     = 1'b1;
  assign w_push_ev.edge_rise = |(r_pend_type & w_sel_oh);
  assign w_push_ev.idx       = w_sel_idx;

  lotr_io_fifo #(
    .W     (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (QClk),
    .i_rst     (RstQnnnH),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (w_push_ev),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  // Debounce state, pending edges, overflow and edge mask
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      r_stable    <= RST_VAL;
      for (int i = 0; i < int'(IN_W); i++) r_cnt[i] <= '0;
      r_pend      <= '0;
      r_pend_type <= '0;
      r_ovf       <= 1'b0;
      r_mask      <= '1;
    end else begin
      r_stable    <= w_stable_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= (r_pend & ~w_clr) | w_set;
      r_pend_type <= (r_pend_type & ~w_set) | (w_stable_nxt & w_set);
      if (|(w_set & r_pend))                     r_ovf <= 1'b1;
      else if (RdEn && (RdAddr == IO_STATUS))    r_ovf <= 1'b0;
      if (WrEn && (WrAddr == IO_MASK))           r_mask <= WrData[IN_W-1:0];
    end
  end

  // Read-port mux from pre-update register values
  always_comb begin
    w_rd_c = '0;
    unique case (RdAddr)
      IO_LEVEL:  w_rd_c = 32'(r_stable);
      IO_EVENT:  w_rd_c = w_empty ? 32'h0 : event_word(w_head);
      IO_STATUS: w_rd_c = {r_ovf, 23'b0, w_full, 3'b0, 4'(w_count)};
      IO_MASK:   w_rd_c = 32'(r_mask);
      default:   w_rd_c = '0;
    endcase
  end

  // Registered read data, read valid and interrupt
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_rd_data  <= RdEn ? w_rd_c : 32'h0;
      r_rd_valid <= RdEn;
      r_irq      <= ~w_empty | r_ovf;
    end
  end

  assign RdData     = r_rd_data;
  assign RdValid    = r_rd_valid;
  assign IrqPending = r_irq;

endmodule
